// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
//   Request : in_valid, ALUA, ALUB, ALUControl, ALUFlagIn (driven by master)
//             in_ready                                    (driven by slave)
//   Response: out_valid, ALUResult, C, Z, N, V, busy      (driven by slave)
//             out_ready                                   (driven by master)
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALUA;
  logic [WIDTH-1:0] ALUB;
  logic [3:0]       ALUControl;
  logic             ALUFlagIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;
  logic             busy;

  modport master (
    output in_valid, ALUA, ALUB, ALUControl, ALUFlagIn, out_ready,
    input  in_ready, out_valid, ALUResult, C, Z, N, V, busy
  );

  modport slave (
    input  in_valid, ALUA, ALUB, ALUControl, ALUFlagIn, out_ready,
    output in_ready, out_valid, ALUResult, C, Z, N, V, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if.slave -- operands/opcode in, result/flags out,
//           in_ready (idle), out_valid (result held), busy (not idle)
// Non-shift opcodes take one EXEC cycle; shifts move one bit per cycle
// for min(ALUB, WIDTH) cycles. Result and flags stay registered until
// the next operation completes.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_INC = 4'd3,
    OP_DEC = 4'd4, OP_NOT = 4'd5, OP_SUB = 4'd6, OP_XOR = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9
  } op_t;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sh_q;
  logic [3:0]       op_q;
  logic             fin_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             c_q, z_q, n_q, v_q;

  logic             req_shift;
  logic [CNT_W-1:0] cnt_load;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] ex_res;
  logic             ex_c, ex_v;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic             last_shift;

  // Request decode: saturated shift count taken straight from the bus.
  always_comb begin
    req_shift = (bus.ALUControl == OP_SHL) || (bus.ALUControl == OP_SHR);
    cnt_load  = (bus.ALUB >= WIDTH_V) ? CNT_W'(WIDTH) : CNT_W'(bus.ALUB);
  end

  // One-bit shift step; sh_out is the bit leaving the register.
  always_comb begin
    if (op_q == OP_SHL) begin
      sh_nxt = {sh_q[WIDTH-2:0], fin_q};
      sh_out = sh_q[MSB];
    end else begin
      sh_nxt = {fin_q, sh_q[WIDTH-1:1]};
      sh_out = sh_q[0];
    end
    last_shift = (cnt_q == CNT_W'(1));
  end

  // Single-cycle operations, evaluated on the latched request.
  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    x      = fin_q ? b_q : a_q;
    case (op_q)
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_NOT: ex_res = ~x;
      OP_ADD: begin
        {ex_c, ex_res} = {1'b0, a_q} + {1'b0, b_q};
        ex_v = (a_q[MSB] == b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        ex_res = a_q - b_q;
        ex_c   = (a_q >= b_q);
        ex_v   = (a_q[MSB] != b_q[MSB]) && (ex_res[MSB] != a_q[MSB]);
      end
      OP_INC: begin
        ex_res = x + 1'b1;
        ex_c   = &x;
        ex_v   = ~x[MSB] & ex_res[MSB];
      end
      OP_DEC: begin
        ex_res = x - 1'b1;
        ex_c   = ~|x;
        ex_v   = x[MSB] & ~ex_res[MSB];
      end
      // Shift by zero passes A through with no carry.
      OP_SHL, OP_SHR: ex_res = a_q;
      default: ex_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = (req_shift && (cnt_load != '0)) ? SHIFT : EXEC;
      EXEC:  state_d = DONE;
      SHIFT: if (last_shift) state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sh_q  <= '0;
      op_q  <= '0;
      fin_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q   <= bus.ALUA;
          b_q   <= bus.ALUB;
          sh_q  <= bus.ALUA;
          op_q  <= bus.ALUControl;
          fin_q <= bus.ALUFlagIn;
          cnt_q <= cnt_load;
        end
        EXEC: begin
          res_q <= ex_res;
          c_q   <= ex_c;
          v_q   <= ex_v;
          z_q   <= (ex_res == '0);
          n_q   <= ex_res[MSB];
        end
        SHIFT: begin
          sh_q  <= sh_nxt;
          cnt_q <= cnt_q - 1'b1;
          // Outputs only change on the final shift so the previous
          // result stays visible while the shift is in progress.
          if (last_shift) begin
            res_q <= sh_nxt;
            c_q   <= sh_out;
            v_q   <= 1'b0;
            z_q   <= (sh_nxt == '0);
            n_q   <= sh_nxt[MSB];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ALUResult = res_q;
  assign bus.C         = c_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int M    = 1 << W;
  localparam int MAXS = M / 2 - 1;
  localparam int MINS = -(M / 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int e_res, e_c, e_z, e_n, e_v, e_lat;
  int p_res = 0, p_c = 0, p_z = 1, p_n = 0, p_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input int r, input int c, input int z,
                         input int n, input int v);
    chk({tag, "_res"}, bus.ALUResult, r);
    chk({tag, "_C"},   bus.C, c);
    chk({tag, "_Z"},   bus.Z, z);
    chk({tag, "_N"},   bus.N, n);
    chk({tag, "_V"},   bus.V, v);
  endtask

  function automatic int sgn(input int u);
    return (u >= M / 2) ? u - M : u;
  endfunction

  // Reference: results as plain integer arithmetic modulo 2^W.
  task automatic model(input int op, input int a, input int b, input int fin);
    int k, x, s, ext;
    k     = (b > W) ? W : b;
    x     = fin ? b : a;
    e_c   = 0;
    e_v   = 0;
    e_lat = 2;
    case (op)
      0: e_res = a & b;
      1: e_res = a | b;
      2: begin
        s     = a + b;
        e_res = s % M;
        e_c   = (s >= M);
        e_v   = (sgn(a) + sgn(b) > MAXS) || (sgn(a) + sgn(b) < MINS);
      end
      3: begin
        e_res = (x + 1) % M;
        e_c   = (x == M - 1);
        e_v   = (sgn(x) + 1 > MAXS);
      end
      4: begin
        e_res = (x + M - 1) % M;
        e_c   = (x == 0);
        e_v   = (sgn(x) - 1 < MINS);
      end
      5: e_res = (~x) & (M - 1);
      6: begin
        e_res = (a - b + M) % M;
        e_c   = (a >= b);
        e_v   = (sgn(a) - sgn(b) > MAXS) || (sgn(a) - sgn(b) < MINS);
      end
      7: e_res = a ^ b;
      8: begin
        ext   = (a << k) | (fin ? ((1 << k) - 1) : 0);
        e_res = ext % M;
        e_c   = (k > 0) ? ((ext >> W) & 1) : 0;
        e_lat = (k > 0) ? k + 1 : 2;
      end
      9: begin
        ext   = a | (fin ? (((1 << k) - 1) << W) : 0);
        e_res = (ext >> k) % M;
        e_c   = (k > 0) ? ((ext >> (k - 1)) & 1) : 0;
        e_lat = (k > 0) ? k + 1 : 2;
      end
      default: e_res = 0;
    endcase
    e_z = (e_res == 0);
    e_n = (e_res >= M / 2);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge where out_valid is seen.
  task automatic launch(input int op, input int a, input int b, input int fin);
    int edges;
    model(op, a, b, fin);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op[3:0];
    bus.ALUA       = a[W-1:0];
    bus.ALUB       = b[W-1:0];
    bus.ALUFlagIn  = fin[0];
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.ALUA       = W'($urandom);
    bus.ALUB       = W'($urandom);
    bus.ALUControl = 4'($urandom);
    bus.ALUFlagIn  = 1'($urandom);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      chk("busy_run", bus.busy, 1);
      chk("in_ready_run", bus.in_ready, 0);
      chk_out("hold_run", p_res, p_c, p_z, p_n, p_v);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'($urandom_range(0, 1));
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("latency", edges, e_lat);
    chk("busy_done", bus.busy, 1);
    chk_out("result", e_res, e_c, e_z, e_n, e_v);
  endtask

  task automatic release_done();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_rel", bus.out_valid, 0);
    chk("in_ready_rel", bus.in_ready, 1);
    chk("busy_rel", bus.busy, 0);
    chk_out("kept", e_res, e_c, e_z, e_n, e_v);
    p_res = e_res; p_c = e_c; p_z = e_z; p_n = e_n; p_v = e_v;
  endtask

  initial begin
    int op, a, b, fin;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ALUA       = '0;
    bus.ALUB       = '0;
    bus.ALUControl = '0;
    bus.ALUFlagIn  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk_out("rst", 0, 0, 1, 0, 0);
    rst_n = 1'b1;

    launch(2, 8'h7F, 8'h01, 0);
    chk("add_spec_res", bus.ALUResult, 8'h80);
    chk("add_spec_V", bus.V, 1);
    chk("add_spec_lat", e_lat, 2);
    release_done();

    launch(6, 8'h05, 8'h05, 0);
    chk("sub_eq_C", bus.C, 1);
    release_done();
    launch(6, 8'h03, 8'h05, 0);
    chk("sub_lt_res", bus.ALUResult, 8'hFE);
    release_done();

    launch(8, 8'h81, 3, 1);
    chk("shl_spec_res", bus.ALUResult, 8'h0F);
    chk("shl_spec_lat", e_lat, 4);
    release_done();

    launch(9, 8'h01, 9, 0);
    chk("shr_sat_lat", e_lat, 9);
    release_done();

    launch(4, 8'h80, 8'h00, 0);
    release_done();
    launch(3, 8'h10, 8'h7F, 1);
    release_done();
    launch(12, 8'hAA, 8'h55, 1);
    release_done();
    launch(8, 8'hC3, 0, 1);
    release_done();

    // Backpressure with a competing request that must be ignored.
    launch(7, 8'h3C, 8'h0F, 0);
    repeat (5) begin
      bus.in_valid   = 1'b1;
      bus.ALUControl = 4'd2;
      bus.ALUA       = 8'h11;
      bus.ALUB       = 8'h22;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk_out("bp", e_res, e_c, e_z, e_n, e_v);
    end
    bus.in_valid = 1'b0;
    release_done();
    repeat (2) @(negedge clk);
    chk("bp_not_taken", bus.busy, 0);
    launch(2, 8'h11, 8'h22, 0);
    chk("bp_next_res", bus.ALUResult, 8'h33);
    release_done();

    // Reset on the third shift edge of a six-bit shift.
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd8;
    bus.ALUA       = 8'h3C;
    bus.ALUB       = 8'd6;
    bus.ALUFlagIn  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sync_busy", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk_out("mid_rst", 0, 0, 1, 0, 0);
    p_res = 0; p_c = 0; p_z = 1; p_n = 0; p_v = 0;
    repeat (8) @(negedge clk);
    chk("mid_rst_quiet", bus.out_valid, 0);
    launch(3, 8'hFF, 8'h12, 0);
    chk("inc_ff_C", bus.C, 1);
    chk("inc_ff_Z", bus.Z, 1);
    release_done();

    repeat (60) begin
      op  = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, M - 1));
      b   = (op == 8 || op == 9) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, M - 1));
      fin = int'($urandom_range(0, 1));
      launch(op, a, b, fin);
      release_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the width of the internal shift counter.

Interface
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block idle and able to accept an operation.
REQ-007 ALUA  in  WIDTH  operand A.
REQ-008 ALUB  in  WIDTH  operand B; also the shift count for shift opcodes.
REQ-009 ALUControl  in  4  opcode.
REQ-010 ALUFlagIn  in  1  for INC/DEC/NOT, 1 selects B and 0 selects A; for shifts, the fill bit.
REQ-011 out_valid  out  1  result and flags valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 ALUResult  out  WIDTH  registered result.
REQ-014 C, Z, N, V  out  1 each  carry/borrow, zero, negative (result MSB), signed overflow.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE; in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-017 On an edge with in_valid=1 in IDLE, the block SHALL latch ALUA, ALUB, ALUControl and ALUFlagIn; in_valid outside IDLE SHALL be ignored.
REQ-018 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD (A+B), 3 INC, 4 DEC, 5 NOT (bitwise), 6 SUB (A-B), 7 XOR, 8 SHL of A, 9 SHR of A, all in two's complement modulo 2^WIDTH.
REQ-019 Opcodes 10-15 SHALL produce ALUResult=0 with Z=1 and C=N=V=0, using EXEC timing.
REQ-020 For non-shift opcodes, and for shifts with count 0, the FSM SHALL go IDLE->EXEC on accept and EXEC->DONE on the next edge, giving out_valid 2 edges after the accept edge.
REQ-021 For shifts, count SHALL be min(ALUB, WIDTH); if count>0, the FSM SHALL go IDLE->SHIFT on accept.
REQ-022 In SHIFT, the block SHALL shift one bit per edge, inserting ALUFlagIn at the vacated end, and SHALL enter DONE on the edge that performs the last shift, giving out_valid count+1 edges after accept.
REQ-023 C SHALL be defined per opcode:
  - ADD: carry out.
  - SUB: 1 when A>=B (unsigned, no borrow).
  - INC: 1 when the operand was all ones.
  - DEC: 1 when the operand was 0 (borrow).
  - Shifts: the last bit shifted out, or 0 when count=0.
  - All logic opcodes: 0.
REQ-024 V SHALL be the signed overflow for ADD, SUB, INC and DEC, and 0 for all other opcodes.
REQ-025 Z SHALL be (ALUResult==0) and N SHALL be ALUResult[WIDTH-1], both registered with the result.
REQ-026 In DONE, ALUResult and all flags SHALL hold stable until an edge with out_ready=1, which SHALL move the FSM to IDLE.
REQ-027 When DONE exits, ALUResult and the flags SHALL keep their last values while out_valid is low.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 Throughput SHALL be at most one operation per latency+1 edges; accepting a new operation in the same edge that DONE exits SHALL NOT be supported.

Reset
REQ-030 An edge with rst_n=0 SHALL force state=IDLE, ALUResult=0, C=N=V=0, Z=1, out_valid=0, busy=0, in_ready=1 and clear the shift counter, in any state including mid-SHIFT.
REQ-031 After reset, no output SHALL reflect the aborted operation.
REQ-032 rst_n SHALL have no asynchronous effect.

Verification
REQ-033 The bench SHALL cover the following directed scenarios with WIDTH=8:
  - ADD A=0x7F, B=0x01 -> ALUResult=0x80, N=1, V=1, C=0, Z=0; out_valid 2 edges after accept.
  - SUB A=0x05, B=0x05 -> 0x00, Z=1, C=1, V=0; SUB A=0x03, B=0x05 -> 0xFE, C=0, N=1.
  - SHL A=0x81, B=3, ALUFlagIn=1 -> 0x0F, C=0; out_valid exactly 4 edges after accept; busy high throughout.
  - SHR A=0x01, B=9, ALUFlagIn=0 -> count saturates to 8; result 0x00, Z=1, C=0; out_valid 9 edges after accept.
  - Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new op -> result and flags unchanged, in_ready=0, new op not taken; out_ready=1 -> IDLE; the next op is accepted afterwards.
  - Reset mid-SHIFT (SHL B=6, rst_n=0 on the 3rd shift edge) -> next cycle IDLE, ALUResult=0, Z=1, out_valid=0; a following INC A=0xFF -> 0x00, C=1, Z=1.
